mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter Word_Size, default 32, data/address word width in bits.
REQ-002 Parameter Block_Size, default 4, words per cache line (beats per transfer).
REQ-003 Parameter LATENCY, default 4, access latency in cycles; legal range 1..15.
REQ-004 Parameter DEPTH, default 256, storage words; power of two, multiple of Block_Size.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset_pin  input  1  asynchronous, active-low reset.
REQ-007 read_Mem  input  1  line-read request from cache controller.
REQ-008 write_Mem  input  1  line-write request from cache controller.
REQ-009 Addr_Mem  input  Word_Size  word address of requested line.
REQ-010 Data_Mem  inout  Word_Size  driven by this block only during read beats; otherwise high-Z.
REQ-011 ready_mem  output  1  high = idle, request accepted on this edge.
REQ-012 valid_Mem  output  1  high = Data_Mem carries a valid read beat.

Function
REQ-013 Storage: DEPTH x Word_Size array; index = Addr_Mem[log2(DEPTH)-1:0]; upper address bits ignored (aliasing wrap).
REQ-014 Line base = index with low log2(Block_Size) bits forced to 0; beat i addresses base+i, i = 0..Block_Size-1, ascending, regardless of request low bits.
REQ-015 States: IDLE, RLAT, RDATA, WDATA, WBUSY.
REQ-016 IDLE: ready_mem=1, valid_Mem=0; acceptance at edge T when ready_mem=1 and read_Mem or write_Mem; base address latched at T.
REQ-017 Both read_Mem and write_Mem high at acceptance: read wins, write dropped (no storage change).
REQ-018 Read: IDLE->RLAT at T; latency counter loaded LATENCY-1; RLAT->RDATA when counter=0.
REQ-019 RDATA: valid_Mem=1 and Data_Mem=word(base+i) for Block_Size consecutive cycles; first valid cycle is the cycle following edge T+LATENCY; returns to IDLE after last beat.
REQ-020 Read data is sampled from storage per beat (not snapshotted at acceptance).
REQ-021 Write: IDLE->WDATA at T; Data_Mem sampled at edges T+1..T+Block_Size; beat i written to base+i at its capture edge.
REQ-022 WDATA->WBUSY after last capture; WBUSY holds LATENCY cycles, then IDLE.
REQ-023 ready_mem=0 in every non-IDLE state; requests outside IDLE ignored, not queued.
REQ-024 ready_mem and valid_Mem are registered outputs; never simultaneously high.
REQ-025 Back-to-back: request held high on first IDLE cycle after completion is accepted on that edge.
REQ-026 Counter and beat index wrap-free: beat index is log2(Block_Size) bits, latency counter 4 bits.

Reset
REQ-027 reset_pin=0 forces immediately: state=IDLE, ready_mem=0, valid_Mem=0, Data_Mem high-Z, counters=0.
REQ-028 First rising edge with reset_pin=1 sets ready_mem=1.
REQ-029 Storage contents are not cleared by reset; write beats captured before reset remain stored.
REQ-030 Reset mid-read or mid-write abandons the transfer; no further beats driven or captured.

Verification
REQ-031 Write line 0x40 with 0x11,0x22,0x33,0x44 on beats after acceptance -> ready_mem low for exactly 4+LATENCY cycles, then high.
REQ-032 Read 0x42 after REQ-031 (LATENCY=4) -> valid_Mem high 4 cycles starting cycle after edge T+4; data 0x11,0x22,0x33,0x44; Data_Mem high-Z otherwise.
REQ-033 read_Mem and write_Mem both high at acceptance on line 0x40 -> read beats return 0x11..0x44; storage unchanged.
REQ-034 Address 0x140 (DEPTH=256) read -> returns same data as 0x40 (wrap).
REQ-035 reset_pin low during second read beat -> valid_Mem drops asynchronously, Data_Mem high-Z; after release ready_mem=1 next edge; subsequent read of 0x40 returns 0x11..0x44.
REQ-036 read_Mem pulsed during RLAT/WBUSY -> ignored, no extra transfer; request held into IDLE accepted on first idle edge.

Source files
------------

// File: rtl/mem_responder.sv
// Line-oriented memory model answering a cache controller: multi-beat line reads
// after a fixed access latency, and multi-beat line writes followed by a busy period.
module mem_responder #(
    parameter int Word_Size  = 32,
    parameter int Block_Size = 4,
    parameter int LATENCY    = 4,
    parameter int DEPTH      = 256
) (
    input  logic                 clk,
    input  logic                 reset_pin,
    input  logic                 read_Mem,
    input  logic                 write_Mem,
    input  logic [Word_Size-1:0] Addr_Mem,
    inout  wire  [Word_Size-1:0] Data_Mem,
    output logic                 ready_mem,
    output logic                 valid_Mem
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (Block_Size > 1) ? $clog2(Block_Size) : 1;
    localparam logic [AW-1:0] OFFSET_MASK = AW'(Block_Size - 1);
    localparam logic [BW-1:0] LAST_BEAT   = BW'(Block_Size - 1);
    localparam logic [3:0]    LAT_LOAD    = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RLAT,
        RDATA,
        WDATA,
        WBUSY
    } state_t;

    state_t                 state;
    logic [3:0]             lat_cnt;
    logic [BW-1:0]          beat;
    logic [AW-1:0]          base;
    logic [AW-1:0]          req_index;
    logic [AW-1:0]          line_base;
    logic [AW-1:0]          beat_addr;
    logic [Word_Size-1:0]   mem [DEPTH];

    // Upper address bits alias onto the same storage, so only the low index bits matter.
    assign req_index = Addr_Mem[AW-1:0];
    assign line_base = req_index & ~OFFSET_MASK;
    assign beat_addr = base + AW'(beat);

    generate
        if (Word_Size > AW) begin : g_addr_hi
            logic addr_unused;
            assign addr_unused = ^Addr_Mem[Word_Size-1:AW];
        end
    endgenerate

    // Read beats are fetched live from storage each cycle, so the bus follows valid_Mem.
    assign Data_Mem = valid_Mem ? mem[beat_addr] : 'z;

    always_ff @(posedge clk) begin
        if (state == WDATA) begin
            mem[beat_addr] <= Data_Mem;
        end
    end

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            state     <= IDLE;
            ready_mem <= 1'b0;
            valid_Mem <= 1'b0;
            lat_cnt   <= '0;
            beat      <= '0;
            base      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_Mem <= 1'b0;
                    if (ready_mem && (read_Mem || write_Mem)) begin
                        ready_mem <= 1'b0;
                        base      <= line_base;
                        beat      <= '0;
                        // A simultaneous write request is dropped in favour of the read.
                        if (read_Mem) begin
                            state   <= RLAT;
                            lat_cnt <= LAT_LOAD;
                        end else begin
                            state <= WDATA;
                        end
                    end else begin
                        ready_mem <= 1'b1;
                    end
                end
                RLAT: begin
                    if (lat_cnt == 4'd0) begin
                        state     <= RDATA;
                        valid_Mem <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RDATA: begin
                    if (beat == LAST_BEAT) begin
                        state     <= IDLE;
                        valid_Mem <= 1'b0;
                        ready_mem <= 1'b1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                WDATA: begin
                    if (beat == LAST_BEAT) begin
                        state   <= WBUSY;
                        lat_cnt <= LAT_LOAD;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                WBUSY: begin
                    if (lat_cnt == 4'd0) begin
                        state     <= IDLE;
                        ready_mem <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ready_mem <= 1'b0;
                    valid_Mem <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized line traffic for mem_responder, checked against an
// address-arithmetic storage model and the expected handshake timing.
module tb_mem_responder;

    localparam int W   = 32;
    localparam int BLK = 4;
    localparam int LAT = 4;
    localparam int DEP = 256;

    logic          clk;
    logic          reset_pin;
    logic          read_Mem;
    logic          write_Mem;
    logic [W-1:0]  Addr_Mem;
    wire  [W-1:0]  data_bus;
    logic          ready_mem;
    logic          valid_Mem;

    logic [W-1:0]  tb_data;
    logic          tb_drive;
    logic [W-1:0]  ref_mem [DEP];
    logic [W-1:0]  wr_data [BLK];

    int compared;
    int mismatched;

    assign data_bus = tb_drive ? tb_data : 'z;

    mem_responder #(
        .Word_Size (W),
        .Block_Size(BLK),
        .LATENCY   (LAT),
        .DEPTH     (DEP)
    ) dut (
        .clk      (clk),
        .reset_pin(reset_pin),
        .read_Mem (read_Mem),
        .write_Mem(write_Mem),
        .Addr_Mem (Addr_Mem),
        .Data_Mem (data_bus),
        .ready_mem(ready_mem),
        .valid_Mem(valid_Mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int line_index(input logic [W-1:0] a);
        return ((int'(a) & (DEP - 1)) / BLK) * BLK;
    endfunction

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!ready_mem && guard < 64) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check_output("wait_ready", ready_mem, 1);
    endtask

    // Starting at the negedge just after the acceptance edge, follow the whole read.
    task automatic read_sequence(input logic [W-1:0] addr, input bit pulse);
        read_Mem  = 1'b0;
        write_Mem = 1'b0;
        check_output("read_accept_ready", ready_mem, 0);
        check_output("read_accept_valid", valid_Mem, 0);
        for (int c = 1; c < LAT; c++) begin
            read_Mem = pulse;
            @(posedge clk);
            @(negedge clk);
            check_output("read_lat_valid", valid_Mem, 0);
            check_output("read_lat_ready", ready_mem, 0);
        end
        read_Mem = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("read_beat_valid", valid_Mem, 1);
            check_output("read_beat_ready", ready_mem, 0);
            check_output("read_beat_data", data_bus, ref_mem[line_index(addr) + i]);
        end
        @(posedge clk);
        @(negedge clk);
        check_output("read_done_ready", ready_mem, 1);
        check_output("read_done_valid", valid_Mem, 0);
    endtask

    task automatic do_read(input logic [W-1:0] addr, input bit both, input bit pulse);
        wait_ready();
        read_Mem  = 1'b1;
        write_Mem = both;
        Addr_Mem  = addr;
        @(posedge clk);
        @(negedge clk);
        read_sequence(addr, pulse);
    endtask

    task automatic apply_stimulus(input logic [W-1:0] addr, input bit hold_read, input logic [W-1:0] read_addr);
        int low;
        int guard;
        wait_ready();
        write_Mem = 1'b1;
        Addr_Mem  = addr;
        @(posedge clk);
        @(negedge clk);
        write_Mem = 1'b0;
        low = ready_mem ? 0 : 1;
        for (int i = 0; i < BLK; i++) begin
            tb_data  = wr_data[i];
            tb_drive = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ref_mem[line_index(addr) + i] = wr_data[i];
            if (!ready_mem) low++;
            check_output("write_valid_low", valid_Mem, 0);
        end
        tb_drive = 1'b0;
        if (hold_read) begin
            read_Mem = 1'b1;
            Addr_Mem = read_addr;
        end
        guard = 0;
        while (!ready_mem && guard < 64) begin
            @(posedge clk);
            @(negedge clk);
            if (!ready_mem) low++;
            guard++;
        end
        check_output("write_busy_cycles", low, BLK + LAT);
    endtask

    initial begin
        logic [W-1:0] addr;
        int           line;
        compared   = 0;
        mismatched = 0;
        reset_pin  = 1'b0;
        read_Mem   = 1'b0;
        write_Mem  = 1'b0;
        Addr_Mem   = '0;
        tb_data    = '0;
        tb_drive   = 1'b0;

        #12;
        check_output("reset_ready", ready_mem, 0);
        check_output("reset_valid", valid_Mem, 0);
        @(negedge clk);
        reset_pin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("ready_after_reset", ready_mem, 1);

        $display("[TB] line write 0x40 and readback");
        wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_data[2] = 32'h33; wr_data[3] = 32'h44;
        apply_stimulus(32'h40, 1'b0, '0);
        do_read(32'h42, 1'b0, 1'b0);

        $display("[TB] simultaneous read and write, then aliased read");
        do_read(32'h40, 1'b1, 1'b0);
        do_read(32'h140, 1'b0, 1'b0);

        $display("[TB] reset during second read beat");
        wait_ready();
        read_Mem = 1'b1;
        Addr_Mem = 32'h40;
        @(posedge clk);
        @(negedge clk);
        read_Mem = 1'b0;
        repeat (LAT + 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("mid_read_valid", valid_Mem, 1);
        check_output("mid_read_data", data_bus, ref_mem[16'h41]);
        #2 reset_pin = 1'b0;
        #1;
        check_output("reset_read_valid", valid_Mem, 0);
        check_output("reset_read_ready", ready_mem, 0);
        @(negedge clk);
        reset_pin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("release_ready", ready_mem, 1);
        check_output("release_valid", valid_Mem, 0);
        do_read(32'h40, 1'b0, 1'b0);

        $display("[TB] reset during write keeps earlier beats only");
        for (int i = 0; i < BLK; i++) wr_data[i] = $urandom;
        apply_stimulus(32'h80, 1'b0, '0);
        wait_ready();
        write_Mem = 1'b1;
        Addr_Mem  = 32'h83;
        @(posedge clk);
        @(negedge clk);
        write_Mem = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tb_data  = $urandom;
            tb_drive = 1'b1;
            if (i < 2) begin
                ref_mem[16'h80 + i] = tb_data;
                @(posedge clk);
                @(negedge clk);
            end
        end
        #2 reset_pin = 1'b0;
        #1;
        check_output("reset_write_ready", ready_mem, 0);
        @(negedge clk);
        @(negedge clk);
        tb_drive  = 1'b0;
        reset_pin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("release_write_ready", ready_mem, 1);
        do_read(32'h80, 1'b0, 1'b0);

        $display("[TB] requests during latency and busy periods");
        do_read(32'h81, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_output("no_extra_valid", valid_Mem, 0);
            check_output("no_extra_ready", ready_mem, 1);
        end
        for (int i = 0; i < BLK; i++) wr_data[i] = $urandom;
        apply_stimulus(32'hC4, 1'b1, 32'h243);
        @(posedge clk);
        @(negedge clk);
        read_sequence(32'h243, 1'b0);

        $display("[TB] randomized line traffic");
        for (int n = 0; n < 6; n++) begin
            line = int'($urandom_range(0, DEP / BLK - 1));
            for (int i = 0; i < BLK; i++) wr_data[i] = $urandom;
            addr = ($urandom & ~32'hFF) | 32'(line * BLK + int'($urandom_range(0, BLK - 1)));
            apply_stimulus(addr, 1'b0, '0);
            addr = ($urandom & ~32'hFF) | 32'(line * BLK + int'($urandom_range(0, BLK - 1)));
            do_read(addr, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
